// File: rtl/cluster_pwr_seq.sv
// cluster_pwr_seq: cluster power-up / power-down sequencer.
// Sequence OFF -> PWR -> ISO -> RST -> ON, with DN as a one-cycle
// teardown step on the way back to OFF and ERR for loss of power-good.
// Optional feature macro: CLUSTER_PWR_SEQ_TIMEOUT_EN adds a power-good
// wait limit of TIMEOUT cycles in PWR, after which the sequencer goes to ERR.
module cluster_pwr_seq #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned PWR_DLY   = 16,
  parameter int unsigned RST_DLY   = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_on_i,
  input  logic       req_off_i,
  input  logic       pwr_ok_i,
  output logic       cluster_pow_o,
  output logic       cluster_byp_o,
  output logic       cluster_rstn_o,
  output logic       cluster_fetch_enable_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,
    ST_PWR = 3'd1,
    ST_ISO = 3'd2,
    ST_RST = 3'd3,
    ST_ON  = 3'd4,
    ST_DN  = 3'd5,
    ST_ERR = 3'd6
  } state_t;

  // Counter reload values: a load of N-1 gives N cycles before the exit at 0.
  localparam logic [CNT_WIDTH-1:0] PWR_LOAD = CNT_WIDTH'(PWR_DLY - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LOAD = CNT_WIDTH'(RST_DLY - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LOAD = CNT_WIDTH'(TIMEOUT - 1);

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt,   w_cnt_nxt;
  logic r_pow,   w_pow_nxt;
  logic r_byp,   w_byp_nxt;
  logic r_rstn,  w_rstn_nxt;
  logic r_fetch, w_fetch_nxt;
  logic r_busy,  w_busy_nxt;
  logic r_err,   w_err_nxt;

  // State, counter and registered outputs; reset forces the safe OFF values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_pow   <= 1'b0;
      r_byp   <= 1'b1;
      r_rstn  <= 1'b0;
      r_fetch <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pow   <= w_pow_nxt;
      r_byp   <= w_byp_nxt;
      r_rstn  <= w_rstn_nxt;
      r_fetch <= w_fetch_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next state and counter, then output values decoded from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_pow_nxt   = 1'b0;
    w_byp_nxt   = 1'b1;
    w_rstn_nxt  = 1'b0;
    w_fetch_nxt = 1'b0;
    w_busy_nxt  = 1'b0;

    case (r_state)
      ST_OFF: begin
        // req_off_i has priority, so both high keeps the cluster off.
        if (!req_off_i && req_on_i) begin
          w_state_nxt = ST_PWR;
          w_cnt_nxt   = TMO_LOAD;
          w_err_nxt   = 1'b0;
        end
      end
      ST_PWR: begin
        if (req_off_i) begin
          w_state_nxt = ST_DN;
        end else if (pwr_ok_i) begin
          w_state_nxt = ST_ISO;
          w_cnt_nxt   = PWR_LOAD;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
`endif
        end
      end
      ST_ISO: begin
        if (!pwr_ok_i) begin
          w_state_nxt = ST_ERR;
        end else if (req_off_i) begin
          w_state_nxt = ST_DN;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RST;
          w_cnt_nxt   = RST_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
        end
      end
      ST_RST: begin
        if (!pwr_ok_i) begin
          w_state_nxt = ST_ERR;
        end else if (req_off_i) begin
          w_state_nxt = ST_DN;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_ON;
        end else begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
        end
      end
      ST_ON: begin
        if (!pwr_ok_i) begin
          w_state_nxt = ST_ERR;
        end else if (req_off_i) begin
          w_state_nxt = ST_DN;
        end
      end
      ST_DN:   w_state_nxt = ST_OFF;
      ST_ERR: begin
        if (req_off_i) begin
          w_state_nxt = ST_OFF;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase

    case (w_state_nxt)
      ST_PWR, ST_ISO: begin
        w_pow_nxt  = 1'b1;
        w_busy_nxt = 1'b1;
      end
      ST_RST: begin
        w_pow_nxt  = 1'b1;
        w_byp_nxt  = 1'b0;
        w_busy_nxt = 1'b1;
      end
      ST_ON: begin
        w_pow_nxt   = 1'b1;
        w_byp_nxt   = 1'b0;
        w_rstn_nxt  = 1'b1;
        w_fetch_nxt = 1'b1;
      end
      ST_DN: begin
        // Core stops first; isolation and power keep their value one more cycle.
        w_pow_nxt  = 1'b1;
        w_byp_nxt  = r_byp;
        w_busy_nxt = 1'b1;
      end
      ST_ERR:  w_err_nxt = 1'b1;
      default: ;
    endcase
  end

  assign cluster_pow_o          = r_pow;
  assign cluster_byp_o          = r_byp;
  assign cluster_rstn_o         = r_rstn;
  assign cluster_fetch_enable_o = r_fetch;
  assign busy_o                 = r_busy;
  assign err_o                  = r_err;
  assign state_o                = r_state;

endmodule
